br_resolve_queue: RTL

//  Tracks in-flight conditional-branch predictions between decode and execute. Each

---
 rtl/br_resolve_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/br_resolve_queue.sv
// In-flight conditional-branch queue between decode and execute: checks each resolved
// prediction against its outcome, raises pre_wrong with the fetch redirect PC on a miss.
module br_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       push_valid,
  input  logic                       push_taken,
  input  logic [ADDR_W-1:0]          push_pc,
  input  logic [ADDR_W-1:0]          push_target,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       pre_wrong,
  output logic [ADDR_W-1:0]          redirect_pc,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           br_count,
  output logic [CNT_W-1:0]           miss_count,
  output logic [1:0]                 err_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              pre_wrong_q, pre_wrong_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [1:0]        err_q, err_d;

  logic              pred_mem [DEPTH];
  logic [ADDR_W-1:0] alt_mem  [DEPTH];

  logic              full_w, empty_w, head_pred, do_pop, miss, do_push, drop, wr_en;
  logic [ADDR_W-1:0] head_alt, alt_pc;

  assign full_w    = (occ_q == OCC_W'(DEPTH));
  assign empty_w   = (occ_q == '0);
  assign head_pred = pred_mem[rd_ptr_q];
  assign head_alt  = alt_mem[rd_ptr_q];

  // A miss squashes everything younger, including a push arriving in the same cycle.
  assign do_pop  = resolve_valid & ~empty_w;
  assign miss    = do_pop & (head_pred != resolve_taken);
  assign do_push = push_valid & ~miss & (~full_w | do_pop);
  assign drop    = push_valid & full_w & ~do_pop;
  assign wr_en   = ~stall & do_push;
  assign alt_pc  = push_taken ? push_pc + ADDR_W'(4) : push_target;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    pre_wrong_d = pre_wrong_q;
    redirect_d  = redirect_q;
    br_cnt_d    = br_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = err_q;
    if (!stall) begin
      pre_wrong_d = miss;
      if (miss) redirect_d = head_alt;
      if (do_pop && br_cnt_q != '1)  br_cnt_d   = br_cnt_q + 1'b1;
      if (miss && miss_cnt_q != '1)  miss_cnt_d = miss_cnt_q + 1'b1;
      if (drop)                      err_d[0]   = 1'b1;
      if (resolve_valid && empty_w)  err_d[1]   = 1'b1;
      if (miss) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        occ_d    = '0;
      end else begin
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
          2'b10:   occ_d = occ_q + 1'b1;
          2'b01:   occ_d = occ_q - 1'b1;
          default: occ_d = occ_q;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      pre_wrong_q <= 1'b0;
      redirect_q  <= '0;
      br_cnt_q    <= '0;
      miss_cnt_q  <= '0;
      err_q       <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      pre_wrong_q <= pre_wrong_d;
      redirect_q  <= redirect_d;
      br_cnt_q    <= br_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
    end
  end

  // NOTE: entry storage is not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      pred_mem[wr_ptr_q] <= push_taken;
      alt_mem[wr_ptr_q]  <= alt_pc;
    end
  end

  assign pre_wrong   = pre_wrong_q;
  assign redirect_pc = redirect_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign occupancy   = occ_q;
  assign br_count    = br_cnt_q;
  assign miss_count  = miss_cnt_q;
  assign err_sticky  = err_q;

endmodule
